// File: rtl/cpu_io_agent_pkg.sv
// cpu_io_agent_pkg
//   Shared types and constants for the CPU I/O agent:
//     - IO_W            : byte width of every data path (8)
//     - agent_state_e   : delivery FSM states IDLE / PULSE / HOLD
//     - CPU_INPUT_RST   : reset value driven on the CPU INPUT bus
//     - HOST_OUT_DATA_RST: reset value of the captured-output byte
//     - cnt_width()     : width of the shared PULSE/HOLD down-counter
package cpu_io_agent_pkg;

  localparam int unsigned IO_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } agent_state_e;

  localparam logic [IO_W-1:0] CPU_INPUT_RST     = '0;
  localparam logic [IO_W-1:0] HOST_OUT_DATA_RST = '0;

  // One counter serves both timed states, so it is sized for the longer one.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cpu_io_agent_if.sv
// cpu_io_agent_if
//   Bundles the host streams and the CPU pin-level signals of cpu_io_agent.
//   modport slave  : the agent itself
//   modport master : whatever drives the agent (host logic / CPU / bench)
//   Host in stream : HOST_IN_DATA, HOST_IN_VALID, HOST_IN_READY
//   CPU pins       : CPU_INPUT, CPU_INTR, CPU_OUTPUT
//   Host out stream: HOST_OUT_DATA, HOST_OUT_VALID, HOST_OUT_READY
//   Status         : OVF (sticky dropped capture), BUSY (delivery in progress)
interface cpu_io_agent_if;
  import cpu_io_agent_pkg::*;

  logic [IO_W-1:0] HOST_IN_DATA;
  logic            HOST_IN_VALID;
  logic            HOST_IN_READY;
  logic [IO_W-1:0] CPU_INPUT;
  logic            CPU_INTR;
  logic [IO_W-1:0] CPU_OUTPUT;
  logic [IO_W-1:0] HOST_OUT_DATA;
  logic            HOST_OUT_VALID;
  logic            HOST_OUT_READY;
  logic            OVF;
  logic            BUSY;

  modport master (
    output HOST_IN_DATA, HOST_IN_VALID, CPU_OUTPUT, HOST_OUT_READY,
    input  HOST_IN_READY, CPU_INPUT, CPU_INTR, HOST_OUT_DATA, HOST_OUT_VALID,
           OVF, BUSY
  );

  modport slave (
    input  HOST_IN_DATA, HOST_IN_VALID, CPU_OUTPUT, HOST_OUT_READY,
    output HOST_IN_READY, CPU_INPUT, CPU_INTR, HOST_OUT_DATA, HOST_OUT_VALID,
           OVF, BUSY
  );

endinterface

// File: rtl/cpu_io_agent_fifo.sv
// cpu_io_agent_fifo
//   Synchronous FIFO for host bytes waiting to be delivered to the CPU.
//   Ports:
//     clk, rst_n : rising-edge clock, asynchronous active-low reset
//     push/wdata : write request and data (ignored when full)
//     pop/rdata  : read request (ignored when empty); rdata shows the head
//     full/empty : occupancy flags, combinational from the count
//   DEPTH must be a power of two (pointers wrap by natural overflow).
module cpu_io_agent_fifo
  import cpu_io_agent_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [IO_W-1:0] wdata,
  output logic [IO_W-1:0] rdata,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [IO_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  // Full refuses a push even when a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cpu_io_agent.sv
// cpu_io_agent
//   Host-side I/O agent for the CPU's INPUT / OUTPUT / INTR_in pins.
//   Bytes from the host stream are queued, then presented one at a time on
//   CPU_INPUT with a CPU_INTR pulse of INTR_CYCLES, followed by a HOLD_CYCLES
//   guard before the next byte. New values driven by the CPU on CPU_OUTPUT
//   are captured and returned to the host as a valid/ready stream.
//   Ports:
//     CLK : rising-edge clock
//     RST : asynchronous active-low reset
//     bus : cpu_io_agent_if.slave (host streams, CPU pins, OVF, BUSY)
//   Build option:
//     CPU_IO_AGENT_OUT_CAPTURE_EN defined   -> output capture implemented
//     CPU_IO_AGENT_OUT_CAPTURE_EN undefined -> HOST_OUT_DATA/VALID and OVF
//                                              tied to 0, CPU_OUTPUT ignored
module cpu_io_agent
  import cpu_io_agent_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned INTR_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input logic           CLK,
  input logic           RST,
  cpu_io_agent_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(INTR_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] INTR_LOAD = CNT_W'(INTR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  // ---------------------------------------------------------------- input FIFO
  logic            fifo_pop;
  logic [IO_W-1:0] fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;

  cpu_io_agent_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (bus.HOST_IN_VALID),
    .pop   (fifo_pop),
    .wdata (bus.HOST_IN_DATA),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.HOST_IN_READY = !fifo_full;

  // ------------------------------------------------------------ delivery FSM
  agent_state_e    state,     state_nxt;
  logic [CNT_W-1:0] cnt,      cnt_nxt;
  logic [IO_W-1:0] cpu_input, cpu_input_nxt;
  logic            cpu_intr,  cpu_intr_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      cpu_input <= CPU_INPUT_RST;
      cpu_intr  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cpu_input <= cpu_input_nxt;
      cpu_intr  <= cpu_intr_nxt;
    end
  end

  // The counter is loaded with (cycles-1) on entry and the state is left
  // when it reads zero, so each timed state lasts exactly its cycle count.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cpu_input_nxt = cpu_input;
    cpu_intr_nxt  = cpu_intr;
    fifo_pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          cpu_input_nxt = fifo_rdata;
          cpu_intr_nxt  = 1'b1;
          cnt_nxt       = INTR_LOAD;
          state_nxt     = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          cpu_intr_nxt = 1'b0;
          cnt_nxt      = HOLD_LOAD;
          state_nxt    = HOLD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        cpu_intr_nxt = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

  assign bus.CPU_INPUT = cpu_input;
  assign bus.CPU_INTR  = cpu_intr;
  assign bus.BUSY      = (state != IDLE);

  // ---------------------------------------------------------- output capture
`ifdef CPU_IO_AGENT_OUT_CAPTURE_EN
  logic [IO_W-1:0] last_out;
  logic [IO_W-1:0] out_data;
  logic            out_valid;
  logic            ovf;
  logic            out_changed;

  assign out_changed = (bus.CPU_OUTPUT != last_out);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_out  <= '0;
      out_data  <= HOST_OUT_DATA_RST;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      last_out <= bus.CPU_OUTPUT;
      if (out_changed) begin
        // A pending byte being taken this edge frees the slot for the new one.
        if (!out_valid || bus.HOST_OUT_READY) begin
          out_data  <= bus.CPU_OUTPUT;
          out_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (out_valid && bus.HOST_OUT_READY) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.HOST_OUT_DATA  = out_data;
  assign bus.HOST_OUT_VALID = out_valid;
  assign bus.OVF            = ovf;
`else
  logic unused_capture_inputs;
  assign unused_capture_inputs = ^{bus.CPU_OUTPUT, bus.HOST_OUT_READY};

  assign bus.HOST_OUT_DATA  = HOST_OUT_DATA_RST;
  assign bus.HOST_OUT_VALID = 1'b0;
  assign bus.OVF            = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_io_agent.sv
// tb_cpu_io_agent
//   Self-checking bench for cpu_io_agent with default parameters. The
//   reference model is time-based: a byte queue plus the edge index of the
//   last delivery, from which interrupt, busy and next-delivery times follow.
module tb_cpu_io_agent;

  localparam int DEPTH = 4;
  localparam int INTR  = 2;
  localparam int HOLD  = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  cpu_io_agent_if bus();

  cpu_io_agent #(
    .FIFO_DEPTH  (DEPTH),
    .INTR_CYCLES (INTR),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------- reference model
  logic [7:0] q[$];
  int         ecount;
  int         last_pop;
  logic [7:0] m_in;
  logic [7:0] m_last;
  logic [7:0] m_odata;
  logic       m_oval;
  logic       m_ovf;

  task automatic model_reset();
    q.delete();
    ecount   = 0;
    last_pop = -1000;
    m_in     = 8'h00;
    m_last   = 8'h00;
    m_odata  = 8'h00;
    m_oval   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit was_full, do_pop, do_push;
    ecount++;
    was_full = (q.size() >= DEPTH);
    do_pop   = (q.size() != 0) && (ecount >= last_pop + INTR + HOLD + 1);
    do_push  = bus.HOST_IN_VALID && !was_full;
    if (do_pop) begin
      m_in     = q.pop_front();
      last_pop = ecount;
    end
    if (do_push) q.push_back(bus.HOST_IN_DATA);
`ifdef CPU_IO_AGENT_OUT_CAPTURE_EN
    if (bus.CPU_OUTPUT != m_last) begin
      if (!m_oval || bus.HOST_OUT_READY) begin
        m_odata = bus.CPU_OUTPUT;
        m_oval  = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_oval && bus.HOST_OUT_READY) begin
      m_oval = 1'b0;
    end
    m_last = bus.CPU_OUTPUT;
`endif
  endtask

  function automatic logic [20:0] model_vec();
    logic intr, busy, ready;
    intr  = (ecount - last_pop) < INTR;
    busy  = (ecount - last_pop) < (INTR + HOLD);
    ready = (q.size() < DEPTH);
    return {m_in, intr, busy, ready, m_odata, m_oval, m_ovf};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {bus.CPU_INPUT, bus.CPU_INTR, bus.BUSY, bus.HOST_IN_READY,
            bus.HOST_OUT_DATA, bus.HOST_OUT_VALID, bus.OVF};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    bus.HOST_IN_VALID  = 1'b0;
    bus.HOST_IN_DATA   = 8'h00;
    bus.CPU_OUTPUT     = 8'h00;
    bus.HOST_OUT_READY = 1'b0;
    model_reset();
    #12;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    bus.HOST_IN_VALID  = 1'b0;
    bus.HOST_IN_DATA   = 8'h00;
    bus.CPU_OUTPUT     = 8'h00;
    bus.HOST_OUT_READY = 1'b0;
    RST = 1'b0;
    model_reset();
    #3;
    checks++;
    if (bus.CPU_INPUT !== 8'h00) begin
      errors++; $display("FAIL reset_cpu_input got %0h want 00", bus.CPU_INPUT);
    end
    checks++;
    if (bus.CPU_INTR !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_intr_busy got %b%b want 00", bus.CPU_INTR, bus.BUSY);
    end
    checks++;
    if (bus.HOST_IN_READY !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", bus.HOST_IN_READY);
    end
    checks++;
    if (bus.HOST_OUT_DATA !== 8'h00 || bus.HOST_OUT_VALID !== 1'b0 || bus.OVF !== 1'b0) begin
      errors++; $display("FAIL reset_out got %0h/%b/%b want 00/0/0",
                         bus.HOST_OUT_DATA, bus.HOST_OUT_VALID, bus.OVF);
    end
    #12;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_single_push();
    int first_rise = -1;
    int hi_count   = 0;
    int busy_fall  = -1;
    bus.HOST_IN_DATA  = 8'hA5;
    bus.HOST_IN_VALID = 1'b1;
    tick();
    bus.HOST_IN_VALID = 1'b0;
    checks++;
    if (bus.CPU_INTR !== 1'b0) begin
      errors++; $display("FAIL single_intr_early got %b want 0", bus.CPU_INTR);
    end
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL single_vec cyc %0d got %h want %h", i, dut_vec(), model_vec());
      end
      if (bus.CPU_INTR === 1'b1) begin
        hi_count++;
        if (first_rise < 0) first_rise = i;
      end
      if (bus.BUSY === 1'b0 && busy_fall < 0 && i > 1) busy_fall = i;
    end
    checks++;
    if (bus.CPU_INPUT !== 8'hA5) begin
      errors++; $display("FAIL single_data got %0h want a5", bus.CPU_INPUT);
    end
    checks++;
    if (first_rise != 1 || hi_count != 2) begin
      errors++; $display("FAIL single_pulse got rise %0d len %0d want rise 1 len 2", first_rise, hi_count);
    end
    checks++;
    if (busy_fall != 19) begin
      errors++; $display("FAIL single_busy_fall got %0d want 19", busy_fall);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[5];
    logic [7:0] got[$];
    int         rise_t[$];
    int         accepted   = 0;
    int         first_low  = -1;
    int         first_back = -1;
    logic       prev_intr  = 1'b0;
    sent[0] = 8'h5A;
    for (int b = 1; b < 5; b++) sent[b] = 8'($urandom);
    for (int cyc = 0; cyc < 120; cyc++) begin
      bus.HOST_IN_VALID = 1'b0;
      if (cyc == 0) begin
        bus.HOST_IN_VALID = 1'b1;
        bus.HOST_IN_DATA  = sent[0];
      end else if (cyc >= 2 && cyc <= 6) begin
        bus.HOST_IN_VALID = 1'b1;
        bus.HOST_IN_DATA  = (cyc <= 5) ? sent[cyc-1] : 8'hEE;
        if (bus.HOST_IN_READY === 1'b1) accepted++;
      end
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL b2b_vec cyc %0d got %h want %h", cyc, dut_vec(), model_vec());
      end
      if (bus.CPU_INTR === 1'b1 && !prev_intr) begin
        got.push_back(bus.CPU_INPUT);
        rise_t.push_back(cyc);
      end
      prev_intr = bus.CPU_INTR;
      if (bus.HOST_IN_READY === 1'b0 && first_low < 0) first_low = cyc;
      if (bus.HOST_IN_READY === 1'b1 && first_low >= 0 && first_back < 0) first_back = cyc;
    end
    bus.HOST_IN_VALID = 1'b0;
    checks++;
    if (accepted != 4) begin
      errors++; $display("FAIL b2b_accepted got %0d want 4", accepted);
    end
    checks++;
    if (first_low != 5 || first_back != 20) begin
      errors++; $display("FAIL b2b_ready_window got %0d..%0d want 5..20", first_low, first_back);
    end
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL b2b_count got %0d want 5", got.size());
    end else begin
      for (int b = 0; b < 5; b++) begin
        checks++;
        if (got[b] !== sent[b] || rise_t[b] != 1 + 19 * b) begin
          errors++; $display("FAIL b2b_byte%0d got %0h@%0d want %0h@%0d",
                             b, got[b], rise_t[b], sent[b], 1 + 19 * b);
        end
      end
    end
  endtask

  task automatic test_capture();
`ifdef CPU_IO_AGENT_OUT_CAPTURE_EN
    bus.HOST_OUT_READY = 1'b1;
    bus.CPU_OUTPUT     = 8'h3C;
    tick();
    checks++;
    if (bus.HOST_OUT_VALID !== 1'b1 || bus.HOST_OUT_DATA !== 8'h3C) begin
      errors++; $display("FAIL cap_load got %b/%0h want 1/3c", bus.HOST_OUT_VALID, bus.HOST_OUT_DATA);
    end
    tick();
    checks++;
    if (bus.HOST_OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL cap_consume got %b want 0", bus.HOST_OUT_VALID);
    end
    bus.HOST_OUT_READY = 1'b0;
    bus.CPU_OUTPUT     = 8'h11;
    tick();
    bus.CPU_OUTPUT     = 8'h22;
    tick();
    checks++;
    if (bus.HOST_OUT_DATA !== 8'h11 || bus.OVF !== 1'b1 || bus.HOST_OUT_VALID !== 1'b1) begin
      errors++; $display("FAIL cap_ovf got %0h/%b/%b want 11/1/1",
                         bus.HOST_OUT_DATA, bus.OVF, bus.HOST_OUT_VALID);
    end
    bus.HOST_OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.OVF !== 1'b1 || bus.HOST_OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL cap_ovf_sticky got %b/%b want 1/0", bus.OVF, bus.HOST_OUT_VALID);
    end
`else
    for (int i = 0; i < 20; i++) begin
      bus.CPU_OUTPUT     = 8'($urandom);
      bus.HOST_OUT_READY = 1'($urandom);
      tick();
      checks++;
      if (bus.HOST_OUT_VALID !== 1'b0 || bus.OVF !== 1'b0 || bus.HOST_OUT_DATA !== 8'h00) begin
        errors++; $display("FAIL nocap_out got %b/%b/%0h want 0/0/00",
                           bus.HOST_OUT_VALID, bus.OVF, bus.HOST_OUT_DATA);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int intr_seen = 0;
    apply_reset();
    for (int cyc = 0; cyc <= 20; cyc++) begin
      bus.HOST_IN_VALID = (cyc <= 4);
      bus.HOST_IN_DATA  = 8'(8'h40 + cyc);
      tick();
    end
    bus.HOST_IN_VALID = 1'b0;
    checks++;
    if (bus.CPU_INTR !== 1'b1 || q.size() != 3) begin
      errors++; $display("FAIL mid_setup got intr %b queued %0d want 1/3", bus.CPU_INTR, q.size());
    end
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.CPU_INTR !== 1'b0 || bus.CPU_INPUT !== 8'h00 ||
        bus.HOST_IN_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL mid_async got intr %b in %0h rdy %b busy %b want 0 00 1 0",
                         bus.CPU_INTR, bus.CPU_INPUT, bus.HOST_IN_READY, bus.BUSY);
    end
    #10;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.CPU_INTR === 1'b1) intr_seen++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL mid_vec cyc %0d got %h want %h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (intr_seen != 0) begin
      errors++; $display("FAIL mid_no_delivery got %0d intr cycles want 0", intr_seen);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      bus.HOST_IN_VALID  = ($urandom_range(0, 3) == 0);
      bus.HOST_IN_DATA   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.CPU_OUTPUT = 8'($urandom);
      bus.HOST_OUT_READY = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL rand_vec cyc %0d got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_capture();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_io_agent.md
# cpu_io_agent

Host-side I/O agent on the far end of the CPU's `INPUT` / `OUTPUT` / `INTR_in` pins. It queues bytes from a host valid/ready stream and presents each one on the CPU's `INPUT` bus, announcing it with an interrupt pulse. It also captures every new value the CPU drives on `OUTPUT` and returns it to the host as a valid/ready stream. It replaces ad-hoc bench stimulus for I/O and interrupt programs, both in simulation and on board.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: input queue depth. Must be a power of 2 and at least 2.
- `INTR_CYCLES`, 2: cycles `CPU_INTR` stays high per delivered byte. Must be at least 1.
- `HOLD_CYCLES`, 16: cycles the byte is held after the pulse, before the next delivery may start. Must be at least 1.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `HOST_IN_DATA` in 8: byte from the host, destined for the CPU.
- `HOST_IN_VALID` in 1: host byte is valid.
- `HOST_IN_READY` out 1: equals !full.
- `CPU_INPUT` out 8: connects to CPU `INPUT`.
- `CPU_INTR` out 1: connects to CPU `INTR_in`.
- `CPU_OUTPUT` in 8: connects to CPU `OUTPUT`.
- `HOST_OUT_DATA` out 8: captured CPU output byte.
- `HOST_OUT_VALID` out 1: captured byte pending.
- `HOST_OUT_READY` in 1: host consumes the pending byte.
- `OVF` out 1: sticky flag; a capture was dropped.
- `BUSY` out 1: delivery FSM is not in IDLE.

## Operation
- Reset values:
  - `CPU_INPUT`=0x00, `CPU_INTR`=0, `HOST_OUT_DATA`=0x00, `HOST_OUT_VALID`=0, `OVF`=0, `BUSY`=0.
  - FIFO empty, so `HOST_IN_READY`=1.
  - Last-output register = 0x00.
- Input FIFO:
  - Push when `HOST_IN_VALID && HOST_IN_READY` at a rising edge.
  - `HOST_IN_READY` is combinational from the count. A push is refused when full, even if a pop happens on the same edge.
  - Push and pop on the same edge when not full: count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Delivery FSM:
  - IDLE: if FIFO is non-empty, pop the head into `CPU_INPUT`, set `CPU_INTR`=1 and go to PULSE. Otherwise stay.
  - PULSE: counts `INTR_CYCLES`. On expiry, clear `CPU_INTR` and go to HOLD.
  - HOLD: counts `HOLD_CYCLES`, then goes to IDLE.
  - `CPU_INPUT` keeps the last delivered byte until the next pop. It is never cleared except by reset.
- Output capture:
  - The last-output register samples `CPU_OUTPUT` every edge.
  - A change is detected when `CPU_OUTPUT` differs from the last-output register.
  - On a change, if `!HOST_OUT_VALID || HOST_OUT_READY`: load `HOST_OUT_DATA` and set VALID=1.
  - On a change otherwise: drop the byte and set `OVF`. The last-output register still updates.
  - If `HOST_OUT_VALID && HOST_OUT_READY` with no change: VALID goes to 0.
  - Repeated writes of the same value are not seen. This is a documented limitation.
- `OVF` clears only on reset.
- Reset mid-operation: everything returns immediately (asynchronously) to the reset values. An in-flight interrupt pulse is cut short and queued bytes are discarded.

## Timing
- Push at edge k into an empty FIFO with the FSM in IDLE:
  - `CPU_INPUT`/`CPU_INTR` update at edge k+1.
  - `CPU_INTR` is high for exactly `INTR_CYCLES` cycles, edges k+1 to k+1+`INTR_CYCLES`.
- Minimum delivery period is `INTR_CYCLES`+`HOLD_CYCLES`+1 cycles per byte.
- Output capture: `CPU_OUTPUT` changes before edge m, so `HOST_OUT_VALID`=1 after edge m. Latency is 1 cycle.
- Host handshakes complete on the rising edge where valid and ready are both high.
- The counter width is $clog2(max(`INTR_CYCLES`, `HOLD_CYCLES`)+1).

## Configuration
- `CPU_IO_AGENT_OUT_CAPTURE_EN` defined: output capture is implemented as described above.
- Undefined:
  - `HOST_OUT_DATA`=0x00, `HOST_OUT_VALID`=0 and `OVF`=0 permanently.
  - `CPU_OUTPUT` and `HOST_OUT_READY` are ignored.
  - No last-output register is built.
  - The input and delivery path is unchanged.

## Structure
- `cpu_io_agent_pkg`:
  - FSM state enum: IDLE, PULSE, HOLD.
  - `IO_W`=8.
  - Reset-value constants for `CPU_INPUT` and `HOST_OUT_DATA`.
- Sub-module `cpu_io_agent_fifo`:
  - Parameterised synchronous FIFO: depth, width `IO_W`.
  - Ports: push, pop, data, full, empty.
  - Same async active-low reset.
- FSM and capture logic live in `cpu_io_agent`.

## Test plan
- Reset, then a single push of 0xA5: `CPU_INPUT`=0xA5 and `CPU_INTR` high for 2 cycles starting 1 cycle after the push. `BUSY` falls 19 cycles after the push.
- Burst of 5 pushes with defaults: 4 accepted. `HOST_IN_READY`=0 after the 4th until the first pop. Bytes are delivered in order, 19 cycles apart.
- `CPU_OUTPUT` goes 0x00→0x3C with `HOST_OUT_READY`=1: `HOST_OUT_VALID` pulses 1 cycle with data 0x3C.
- `HOST_OUT_READY`=0, `CPU_OUTPUT` goes 0x11 then 0x22: `HOST_OUT_DATA` stays 0x11 and `OVF`=1 and stays set.
- Assert `RST` low during PULSE with 3 bytes queued: `CPU_INTR`=0 and `CPU_INPUT`=0x00 immediately, `HOST_IN_READY`=1. After release no delivery occurs.
- Build without `CPU_IO_AGENT_OUT_CAPTURE_EN`: toggle `CPU_OUTPUT`; `HOST_OUT_VALID` and `OVF` stay 0.
